// File: rtl/pc_gen_if.sv
// Fetch-side bundle of the PC generator: fetch request handshake plus the
// redirect/trap/stall controls coming back from execute and the CSR unit.
interface pc_gen_if #(
  parameter int unsigned XLEN = 32
);
  logic            i_stall;
  logic            i_fetch_ready;
  logic            i_redirect_valid;
  logic [XLEN-1:0] i_redirect_pc;
  logic            i_trap_valid;
  logic [XLEN-1:0] i_trap_pc;
  logic            o_fetch_valid;
  logic [XLEN-1:0] o_pc;
  logic [XLEN-1:0] o_pc_plus;
  logic            o_misaligned;
  logic            o_pending;

  // PC generator side.
  modport master (
    input  i_stall, i_fetch_ready, i_redirect_valid, i_redirect_pc,
           i_trap_valid, i_trap_pc,
    output o_fetch_valid, o_pc, o_pc_plus, o_misaligned, o_pending
  );

  // Pipeline / instruction-memory side.
  modport slave (
    output i_stall, i_fetch_ready, i_redirect_valid, i_redirect_pc,
           i_trap_valid, i_trap_pc,
    input  o_fetch_valid, o_pc, o_pc_plus, o_misaligned, o_pending
  );
endinterface

// File: rtl/pc_gen.sv
// Fetch program-counter generator. Holds the fetch PC, issues requests over a
// valid/ready handshake, and applies trap > stall > redirect > pending >
// sequential priority. A redirect arriving during a stall is parked in a
// one-entry buffer; a misaligned committed target freezes the PC in FAULT
// until a trap arrives.
module pc_gen #(
  parameter int unsigned     XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = '0,
  parameter int unsigned     INC          = 4,
  parameter int unsigned     ALIGN_BITS   = 2
) (
  input  logic     i_clk,
  input  logic     i_rst,
  pc_gen_if.master bus
);

  // Low bits that must be zero in a legal target (empty mask when ALIGN_BITS=0).
  localparam logic [XLEN-1:0] ALIGN_MASK = XLEN'((64'd1 << ALIGN_BITS) - 64'd1);
  localparam logic [XLEN-1:0] INC_X      = XLEN'(INC);

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    RUN   = 2'd1,
    FAULT = 2'd2
  } state_t;

  state_t          state;
  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] pend_pc;
  logic            pend_valid;
  logic            fetch_valid;
  logic            misaligned;

  logic            fire;
  logic [XLEN-1:0] trap_target;
  logic            commit;
  logic [XLEN-1:0] commit_target;
  logic            commit_bad;

  // Handshake completes only when the request is valid, accepted and not stalled.
  assign fire          = fetch_valid & bus.i_fetch_ready & ~bus.i_stall;
  // Trap vectors are silently aligned rather than faulting.
  assign trap_target   = bus.i_trap_pc & ~ALIGN_MASK;
  // Without a stall, a live redirect beats the buffered one.
  assign commit        = ~bus.i_stall & (bus.i_redirect_valid | pend_valid);
  assign commit_target = bus.i_redirect_valid ? bus.i_redirect_pc : pend_pc;
  assign commit_bad    = |(commit_target & ALIGN_MASK);

  // Single control FSM: PC register, pending buffer and registered status flags.
  // NOTE: every state register uses <= so all updates see pre-edge values;
  // blocking assignments here would create order-dependent simulation races.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state       <= BOOT;
      pc          <= RESET_VECTOR;
      pend_pc     <= '0;
      pend_valid  <= 1'b0;
      fetch_valid <= 1'b0;
      misaligned  <= 1'b0;
    end else begin
      case (state)
        BOOT: begin
          if (bus.i_trap_valid) pc <= trap_target;
          state       <= RUN;
          fetch_valid <= 1'b1;
        end
        RUN: begin
          if (bus.i_trap_valid) begin
            pc         <= trap_target;
            pend_valid <= 1'b0;
          end else if (bus.i_stall) begin
            if (bus.i_redirect_valid) begin
              pend_valid <= 1'b1;
              pend_pc    <= bus.i_redirect_pc;
            end
          end else if (commit) begin
            pc         <= commit_target;
            pend_valid <= 1'b0;
            if (commit_bad) begin
              state       <= FAULT;
              fetch_valid <= 1'b0;
              misaligned  <= 1'b1;
            end
          end else if (fire) begin
            pc <= pc + INC_X;
          end
        end
        FAULT: begin
          if (bus.i_trap_valid) begin
            pc          <= trap_target;
            pend_valid  <= 1'b0;
            state       <= RUN;
            fetch_valid <= 1'b1;
            misaligned  <= 1'b0;
          end
        end
        default: begin
          state       <= BOOT;
          fetch_valid <= 1'b0;
          misaligned  <= 1'b0;
          pend_valid  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.o_pc          = pc;
  assign bus.o_pc_plus     = pc + INC_X;
  assign bus.o_fetch_valid = fetch_valid;
  assign bus.o_misaligned  = misaligned;
  assign bus.o_pending     = pend_valid;

endmodule

// File: tb/tb_pc_gen.sv
// Self-checking bench for pc_gen: directed scenarios plus a randomized run
// compared against a cycle-level behavioural model of the fetch PC rules.
module tb_pc_gen;

  localparam int unsigned XLEN = 32;
  localparam logic [31:0] RV   = 32'h0000_0100;

  localparam int M_BOOT  = 0;
  localparam int M_RUN   = 1;
  localparam int M_FAULT = 2;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   errors = 0;
  int   checks = 0;

  // Model state for the randomized run.
  int          m_mode;
  logic [31:0] m_pc;
  logic [31:0] m_pend_q[$];

  pc_gen_if #(.XLEN(XLEN)) bus ();

  pc_gen #(
    .XLEN(XLEN), .RESET_VECTOR(RV), .INC(4), .ALIGN_BITS(2)
  ) dut (
    .i_clk(clk),
    .i_rst(rst),
    .bus  (bus.master)
  );

  // Free-running 100 MHz clock.
  always #5 clk = ~clk;

  // Watchdog so the run always ends.
  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  // {fetch_valid, misaligned, pending, pc}
  function automatic logic [34:0] obs();
    return {bus.o_fetch_valid, bus.o_misaligned, bus.o_pending, bus.o_pc};
  endfunction

  task automatic idle();
    bus.i_stall          = 1'b0;
    bus.i_fetch_ready    = 1'b1;
    bus.i_redirect_valid = 1'b0;
    bus.i_redirect_pc    = '0;
    bus.i_trap_valid     = 1'b0;
    bus.i_trap_pc        = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reset, release, and step through BOOT so the DUT sits in RUN at RV.
  task automatic do_reset();
    rst = 1'b0;
    idle();
    tick();
    rst = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    logic [34:0] got;
    rst = 1'b0;
    idle();
    #12;
    got = obs();
    checks++;
    if (got !== {3'b000, RV}) begin
      errors++;
      $display("FAIL reset_state: got %b/%h want 000/%h", got[34:32], got[31:0], RV);
    end
    checks++;
    if (bus.o_pc_plus !== 32'h104) begin
      errors++;
      $display("FAIL reset_pc_plus: got %h want 00000104", bus.o_pc_plus);
    end
    @(posedge clk);
    #1;
    rst = 1'b1;
    got = obs();
    checks++;
    if (got !== {3'b000, RV}) begin
      errors++;
      $display("FAIL boot_cycle: got %b/%h want 000/%h", got[34:32], got[31:0], RV);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      got = obs();
      checks++;
      if (got !== {3'b100, RV + 32'(4 * i)}) begin
        errors++;
        $display("FAIL boot_seq%0d: got %b/%h want 100/%h", i, got[34:32], got[31:0], RV + 32'(4 * i));
      end
    end
  endtask

  task automatic test_ready_hold();
    logic [34:0] got;
    do_reset();
    bus.i_trap_valid = 1'b1;
    bus.i_trap_pc    = 32'h10;
    tick();
    bus.i_trap_valid  = 1'b0;
    bus.i_fetch_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      got = obs();
      checks++;
      if (got !== {3'b100, 32'h10}) begin
        errors++;
        $display("FAIL ready_hold%0d: got %b/%h want 100/00000010", i, got[34:32], got[31:0]);
      end
    end
    bus.i_fetch_ready = 1'b1;
    tick();
    got = obs();
    checks++;
    if (got !== {3'b100, 32'h14}) begin
      errors++;
      $display("FAIL ready_advance: got %b/%h want 100/00000014", got[34:32], got[31:0]);
    end
  endtask

  task automatic test_stall_redirect();
    logic [34:0] got;
    bus.i_stall          = 1'b1;
    bus.i_redirect_valid = 1'b1;
    bus.i_redirect_pc    = 32'h200;
    tick();
    bus.i_redirect_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      got = obs();
      checks++;
      if (got !== {3'b101, 32'h14}) begin
        errors++;
        $display("FAIL stall_pending%0d: got %b/%h want 101/00000014", i, got[34:32], got[31:0]);
      end
      if (i < 2) tick();
    end
    bus.i_stall = 1'b0;
    tick();
    got = obs();
    checks++;
    if (got !== {3'b100, 32'h200}) begin
      errors++;
      $display("FAIL stall_release: got %b/%h want 100/00000200", got[34:32], got[31:0]);
    end
  endtask

  task automatic test_trap_priority();
    logic [34:0] got;
    bus.i_stall          = 1'b1;
    bus.i_redirect_valid = 1'b1;
    bus.i_redirect_pc    = 32'h40;
    tick();
    bus.i_trap_valid = 1'b1;
    bus.i_trap_pc    = 32'h8000_0003;
    tick();
    got = obs();
    checks++;
    if (got !== {3'b100, 32'h8000_0000}) begin
      errors++;
      $display("FAIL trap_over_stall: got %b/%h want 100/80000000", got[34:32], got[31:0]);
    end
    idle();
    tick();
    got = obs();
    checks++;
    if (got !== {3'b100, 32'h8000_0004}) begin
      errors++;
      $display("FAIL trap_clears_pending: got %b/%h want 100/80000004", got[34:32], got[31:0]);
    end
  endtask

  task automatic test_fault();
    logic [34:0] got;
    idle();
    bus.i_redirect_valid = 1'b1;
    bus.i_redirect_pc    = 32'h102;
    tick();
    got = obs();
    checks++;
    if (got !== {3'b010, 32'h102}) begin
      errors++;
      $display("FAIL fault_enter: got %b/%h want 010/00000102", got[34:32], got[31:0]);
    end
    for (int i = 0; i < 3; i++) begin
      bus.i_stall          = (i == 1);
      bus.i_redirect_valid = (i < 2);
      bus.i_redirect_pc    = 32'h400 + 32'(4 * i);
      tick();
      got = obs();
      checks++;
      if (got !== {3'b010, 32'h102}) begin
        errors++;
        $display("FAIL fault_hold%0d: got %b/%h want 010/00000102", i, got[34:32], got[31:0]);
      end
    end
    idle();
    bus.i_trap_valid = 1'b1;
    bus.i_trap_pc    = 32'h300;
    tick();
    got = obs();
    checks++;
    if (got !== {3'b100, 32'h300}) begin
      errors++;
      $display("FAIL fault_exit: got %b/%h want 100/00000300", got[34:32], got[31:0]);
    end
    bus.i_trap_valid = 1'b0;
    tick();
    got = obs();
    checks++;
    if (got !== {3'b100, 32'h304}) begin
      errors++;
      $display("FAIL fault_resume: got %b/%h want 100/00000304", got[34:32], got[31:0]);
    end
  endtask

  task automatic test_misaligned_pending();
    logic [34:0] got;
    bus.i_stall          = 1'b1;
    bus.i_redirect_valid = 1'b1;
    bus.i_redirect_pc    = 32'h33;
    tick();
    got = obs();
    checks++;
    if (got !== {3'b101, 32'h304}) begin
      errors++;
      $display("FAIL mis_buffered: got %b/%h want 101/00000304", got[34:32], got[31:0]);
    end
    idle();
    tick();
    got = obs();
    checks++;
    if (got !== {3'b010, 32'h33}) begin
      errors++;
      $display("FAIL mis_commit: got %b/%h want 010/00000033", got[34:32], got[31:0]);
    end
    bus.i_trap_valid = 1'b1;
    bus.i_trap_pc    = 32'h0;
    tick();
    bus.i_trap_valid = 1'b0;
  endtask

  task automatic test_redirect_wins();
    logic [34:0] got;
    bus.i_stall          = 1'b1;
    bus.i_redirect_valid = 1'b1;
    bus.i_redirect_pc    = 32'h500;
    tick();
    got = obs();
    checks++;
    if (got !== {3'b101, 32'h0}) begin
      errors++;
      $display("FAIL rw_capture: got %b/%h want 101/00000000", got[34:32], got[31:0]);
    end
    bus.i_stall       = 1'b0;
    bus.i_redirect_pc = 32'h600;
    tick();
    got = obs();
    checks++;
    if (got !== {3'b100, 32'h600}) begin
      errors++;
      $display("FAIL rw_new_wins: got %b/%h want 100/00000600", got[34:32], got[31:0]);
    end
    idle();
    tick();
    got = obs();
    checks++;
    if (got !== {3'b100, 32'h604}) begin
      errors++;
      $display("FAIL rw_buffer_dropped: got %b/%h want 100/00000604", got[34:32], got[31:0]);
    end
  endtask

  task automatic test_wrap();
    idle();
    bus.i_trap_valid = 1'b1;
    bus.i_trap_pc    = 32'hFFFF_FFFC;
    tick();
    checks++;
    if (bus.o_pc !== 32'hFFFF_FFFC || bus.o_pc_plus !== 32'h0) begin
      errors++;
      $display("FAIL wrap_top: got pc=%h plus=%h want fffffffc/00000000", bus.o_pc, bus.o_pc_plus);
    end
    bus.i_trap_valid = 1'b0;
    tick();
    checks++;
    if (bus.o_pc !== 32'h0 || bus.o_pc_plus !== 32'h4) begin
      errors++;
      $display("FAIL wrap_zero: got pc=%h plus=%h want 00000000/00000004", bus.o_pc, bus.o_pc_plus);
    end
  endtask

  task automatic test_async_reset();
    logic [34:0] got;
    idle();
    @(posedge clk);
    #3;
    rst = 1'b0;
    #1;
    got = obs();
    checks++;
    if (got !== {3'b000, RV} || bus.o_pc_plus !== 32'h104) begin
      errors++;
      $display("FAIL async_reset: got %b/%h plus=%h want 000/%h plus=00000104", got[34:32], got[31:0], bus.o_pc_plus, RV);
    end
    tick();
    rst = 1'b1;
    tick();
    got = obs();
    checks++;
    if (got !== {3'b100, RV}) begin
      errors++;
      $display("FAIL async_rerun: got %b/%h want 100/%h", got[34:32], got[31:0], RV);
    end
  endtask

  // Reference behaviour for one clock edge, from the fetch PC rules.
  task automatic model_step();
    logic [31:0] tgt;
    bit          do_commit;
    do_commit = 0;
    tgt       = '0;
    if (m_mode == M_BOOT) begin
      if (bus.i_trap_valid) m_pc = bus.i_trap_pc - (bus.i_trap_pc % 4);
      m_mode = M_RUN;
    end else if (m_mode == M_FAULT) begin
      if (bus.i_trap_valid) begin
        m_pc   = bus.i_trap_pc - (bus.i_trap_pc % 4);
        m_mode = M_RUN;
        m_pend_q.delete();
      end
    end else if (bus.i_trap_valid) begin
      m_pc = bus.i_trap_pc - (bus.i_trap_pc % 4);
      m_pend_q.delete();
    end else if (bus.i_stall) begin
      if (bus.i_redirect_valid) begin
        m_pend_q.delete();
        m_pend_q.push_back(bus.i_redirect_pc);
      end
    end else if (bus.i_redirect_valid) begin
      m_pend_q.delete();
      tgt       = bus.i_redirect_pc;
      do_commit = 1;
    end else if (m_pend_q.size() != 0) begin
      tgt       = m_pend_q.pop_front();
      do_commit = 1;
    end else if (bus.i_fetch_ready) begin
      m_pc = m_pc + 32'd4;
    end
    if (do_commit) begin
      m_pc = tgt;
      if (tgt % 4 != 0) m_mode = M_FAULT;
    end
  endtask

  task automatic test_random();
    logic [34:0] got;
    logic [34:0] want;
    do_reset();
    m_mode = M_RUN;
    m_pc   = RV;
    m_pend_q.delete();
    for (int i = 0; i < 600; i++) begin
      bus.i_trap_valid     = ($urandom_range(0, 15) == 0);
      bus.i_trap_pc        = $urandom;
      bus.i_redirect_valid = ($urandom_range(0, 4) == 0);
      bus.i_redirect_pc    = ($urandom_range(0, 7) == 0) ? $urandom : ($urandom & 32'hFFFF_FFFC);
      bus.i_stall          = ($urandom_range(0, 2) == 0);
      bus.i_fetch_ready    = 1'($urandom_range(0, 1));
      tick();
      model_step();
      got  = obs();
      want = {m_mode == M_RUN, m_mode == M_FAULT, m_pend_q.size() != 0, m_pc};
      checks++;
      if (got !== want || bus.o_pc_plus !== m_pc + 32'd4) begin
        errors++;
        $display("FAIL random%0d: got %b/%h plus=%h want %b/%h plus=%h", i,
                 got[34:32], got[31:0], bus.o_pc_plus, want[34:32], want[31:0], m_pc + 32'd4);
      end
    end
    idle();
  endtask

  // Scenario sequence and summary.
  initial begin
    idle();
    test_reset();
    test_ready_hold();
    test_stall_redirect();
    test_trap_priority();
    test_fault();
    test_misaligned_pending();
    test_redirect_wins();
    test_wrap();
    test_async_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
